// File: rtl/mem_burst_master_if.sv
// mem_burst_master_if
//   Bundles the host request/response channel and the byte-wide memory port
//   of mem_burst_master.
//
//   Host channel (valid/ready): a request transfers on the rising clock edge
//   where req_valid && req_ready are both high. The initiator holds
//   req_write/req_addr/req_wdata stable while req_valid is high. There is no
//   backpressure on the response: resp_valid is a one-cycle pulse.
//
//   Memory port: mem_addr/mem_wdata/mem_rw are sampled by the memory on every
//   rising edge (the memory acts each cycle); mem_rdata is the memory's
//   registered read byte, one cycle behind the beat that addressed it.
//
//   Modports:
//     master - the burst master (drives mem_*, req_ready, resp_*, busy)
//     slave  - the environment around it (host logic plus memory)
interface mem_burst_master_if #(
    parameter int LINE_W = 7
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [LINE_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              busy;
    logic [7:0]        mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_rw;
    logic [7:0]        mem_rdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy,
               mem_addr, mem_wdata, mem_rw
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy,
               mem_addr, mem_wdata, mem_rw
    );
endinterface

// File: rtl/mem_burst_master.sv
// mem_burst_master
//   Initiator for a 4-beat byte-wide burst memory. Accepts one 32-bit host
//   request (read or write of a 4-byte line) and runs four byte beats on the
//   memory port, aligned to the memory's free-running beat counter. Read bytes
//   are assembled into a 32-bit word returned with resp_valid.
//
//   Ports:
//     clk        in   rising-edge clock
//     rst        in   asynchronous, active-high reset
//     bus        if   mem_burst_master_if.master (host request/response + memory port)
//     dbg_state  out  current FSM state encoding (see state_t)
//
//   Parameters:
//     LINE_W     line address width; mem_addr is the zero-extended line
//     PHASE_RST  beat phase loaded in reset; lines ph up with the memory,
//                which spends one cycle in init after reset
//
//   Optional feature (macro READBACK_CHECK_EN):
//     defined   - every write burst is followed immediately by a read burst of
//                 the same line; the response carries the read-back word and
//                 resp_err flags a mismatch against the written word.
//     undefined - writes respond 4 cycles after their first beat; resp_err is 0.
module mem_burst_master #(
    parameter int         LINE_W    = 7,
    parameter logic [1:0] PHASE_RST = 2'd3
) (
    input  logic                     clk,
    input  logic                     rst,
    mem_burst_master_if.master       bus,
    output logic [2:0]               dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ALIGN  = 3'd1,
        WBURST = 3'd2,
        RBURST = 3'd3,
        RTAIL  = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t      state;
    logic [1:0]  ph;        // beat phase: a cycle with ph==k is memory beat k
    logic        wr_q;
    logic [31:0] wdata_q;
    logic [23:0] rbuf;      // bytes 0..2 of a read; byte 3 is taken straight from mem_rdata

    assign dbg_state = state;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
        return w[{k, 3'b000} +: 8];
    endfunction

    // All outputs are registered: every assignment below sets the value the
    // outputs carry in the NEXT cycle, whose phase is ph+1. A burst therefore
    // starts on the edge that ends a ph==3 cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            ph             <= PHASE_RST;
            wr_q           <= 1'b0;
            wdata_q        <= 32'h0;
            rbuf           <= 24'h0;
            bus.req_ready  <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 32'h0;
            bus.resp_err   <= 1'b0;
            bus.busy       <= 1'b0;
            bus.mem_addr   <= 8'h0;
            bus.mem_wdata  <= 8'h0;
            bus.mem_rw     <= 1'b0;
        end else begin
            ph             <= ph + 2'd1;
            bus.resp_valid <= 1'b0;

            case (state)
                IDLE: begin
                    bus.req_ready <= 1'b1;
                    if (bus.req_valid && bus.req_ready) begin
                        bus.req_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        wr_q          <= bus.req_write;
                        wdata_q       <= bus.req_wdata;
                        bus.mem_addr  <= {{(8-LINE_W){1'b0}}, bus.req_addr};
                        if (ph == 2'd3) begin
                            // Next cycle is beat 0: no ALIGN cycles at all.
                            state         <= bus.req_write ? WBURST : RBURST;
                            bus.mem_rw    <= bus.req_write;
                            bus.mem_wdata <= bus.req_write ? bus.req_wdata[7:0] : 8'h00;
                        end else begin
                            state <= ALIGN;
                        end
                    end
                end

                ALIGN: begin
                    if (ph == 2'd3) begin
                        state         <= wr_q ? WBURST : RBURST;
                        bus.mem_rw    <= wr_q;
                        bus.mem_wdata <= wr_q ? wdata_q[7:0] : 8'h00;
                    end
                end

                WBURST: begin
                    if (ph == 2'd3) begin
                        bus.mem_rw    <= 1'b0;
                        bus.mem_wdata <= 8'h00;
`ifdef READBACK_CHECK_EN
                        // ph is about to be 0, so the read-back burst starts at once.
                        state <= RBURST;
`else
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
`endif
                    end else begin
                        bus.mem_wdata <= byte_of(wdata_q, ph + 2'd1);
                    end
                end

                RBURST: begin
                    // mem_rdata lags the beat by one cycle: in beat k it holds byte k-1.
                    if (ph != 2'd0) begin
                        rbuf[{ph - 2'd1, 3'b000} +: 8] <= bus.mem_rdata;
                    end
                    if (ph == 2'd3) begin
                        state <= RTAIL;
                    end
                end

                RTAIL: begin
                    state          <= RESP;
                    bus.resp_valid <= 1'b1;
                    bus.resp_rdata <= {bus.mem_rdata, rbuf};
`ifdef READBACK_CHECK_EN
                    bus.resp_err   <= wr_q && ({bus.mem_rdata, rbuf} != wdata_q);
`endif
                end

                RESP: begin
                    state         <= IDLE;
                    bus.busy      <= 1'b0;
                    bus.req_ready <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_master.sv
// tb_mem_burst_master
//   Directed bench for mem_burst_master with a byte-wide burst memory model
//   (one init cycle after reset, free-running beat counter, registered read).
module tb_mem_burst_master;

    localparam logic [2:0] S_ALIGN = 3'd1;
`ifdef READBACK_CHECK_EN
    localparam int WR_LAT = 9;   // write response cycles after first beat
`else
    localparam int WR_LAT = 4;
`endif

    logic       clk;
    logic       rst;
    logic [2:0] dbg_state;

    int checks   = 0;
    int failures = 0;

    mem_burst_master_if #(.LINE_W(7)) bus ();

    mem_burst_master #(.LINE_W(7), .PHASE_RST(2'd3)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- memory model ----------------
    logic [7:0] mem_arr [0:511];
    logic [1:0] mph;
    logic       minit;
    logic [7:0] mem_rdata_r;
    logic       corrupt_b2;

    assign bus.mem_rdata = mem_rdata_r;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            minit       <= 1'b1;
            mph         <= 2'd0;
            mem_rdata_r <= 8'h00;
        end else if (minit) begin
            minit <= 1'b0;
        end else begin
            if (bus.mem_rw)
                mem_arr[{bus.mem_addr[6:0], mph}] <= bus.mem_wdata;
            if (corrupt_b2 && !bus.mem_rw && mph == 2'd2)
                mem_rdata_r <= 8'h00;
            else
                mem_rdata_r <= mem_arr[{bus.mem_addr[6:0], mph}];
            mph <= mph + 2'd1;
        end
    end

    // ---------------- driver tasks ----------------
    int          g_rw_cnt, g_first_rw, g_align, g_resp_cnt, g_resp_c;
    logic [31:0] g_wbytes, g_rdata;
    logic        g_err, g_busy1, g_ready1, g_ready_hs;
    logic [7:0]  g_addr1;

    // Called at a negedge; leaves us at the negedge of a cycle whose phase is p.
    task automatic wait_phase(input int p);
        bit found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (!minit && mph == p[1:0]) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL wait_phase got=timeout exp=phase %0d", p);
        end
    endtask

    // Issues one request at phase p and observes 16 following cycles.
    task automatic run_req(input bit wr, input logic [6:0] line, input logic [31:0] wd,
                           input int p);
        wait_phase(p);
        g_ready_hs    = bus.req_ready;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = line;
        bus.req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        g_rw_cnt = 0; g_first_rw = -1; g_align = 0; g_resp_cnt = 0; g_resp_c = -1;
        g_wbytes = 32'h0; g_rdata = 32'h0; g_err = 1'b0;
        g_busy1 = bus.busy; g_ready1 = bus.req_ready; g_addr1 = bus.mem_addr;
        for (int c = 1; c <= 16; c++) begin
            if (bus.mem_rw) begin
                if (g_first_rw < 0) g_first_rw = c;
                if (g_rw_cnt < 4) g_wbytes[g_rw_cnt*8 +: 8] = bus.mem_wdata;
                g_rw_cnt++;
            end
            if (dbg_state == S_ALIGN) g_align++;
            if (bus.resp_valid) begin
                g_resp_cnt++;
                g_resp_c = c;
                g_rdata  = bus.resp_rdata;
                g_err    = bus.resp_err;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 7'h0; bus.req_wdata = 32'h0;
        corrupt_b2 = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready got=%b exp=0", bus.req_ready); end
        checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%b exp=0", bus.resp_valid); end
        checks++; if (bus.resp_rdata !== 32'h0) begin failures++; $display("FAIL rst_resp_rdata got=%h exp=0", bus.resp_rdata); end
        checks++; if (bus.resp_err !== 1'b0) begin failures++; $display("FAIL rst_resp_err got=%b exp=0", bus.resp_err); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        checks++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_rw} !== 17'h0) begin failures++; $display("FAIL rst_mem got=%h/%h/%b exp=0/0/0", bus.mem_addr, bus.mem_wdata, bus.mem_rw); end
        checks++; if (dbg_state !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_after got=%b exp=1", bus.req_ready); end
    endtask

    task automatic test_write();
        run_req(1'b1, 7'h05, 32'hDEADBEEF, 3);
        checks++; if (g_ready_hs !== 1'b1) begin failures++; $display("FAIL wr_ready_hs got=%b exp=1", g_ready_hs); end
        checks++; if (g_addr1 !== 8'h05) begin failures++; $display("FAIL wr_addr got=%h exp=05", g_addr1); end
        checks++; if (g_rw_cnt !== 4) begin failures++; $display("FAIL wr_rw_cycles got=%0d exp=4", g_rw_cnt); end
        checks++; if (g_first_rw !== 1) begin failures++; $display("FAIL wr_first_beat got=%0d exp=1", g_first_rw); end
        checks++; if (g_wbytes !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_bytes got=%h exp=deadbeef (EF,BE,AD,DE)", g_wbytes); end
        checks++; if (g_resp_cnt !== 1) begin failures++; $display("FAIL wr_resp_cnt got=%0d exp=1", g_resp_cnt); end
        checks++; if (g_resp_c !== 1 + WR_LAT) begin failures++; $display("FAIL wr_resp_cycle got=%0d exp=%0d", g_resp_c, 1 + WR_LAT); end
        checks++; if (g_busy1 !== 1'b1 || g_ready1 !== 1'b0) begin failures++; $display("FAIL wr_busy_ready got=%b/%b exp=1/0", g_busy1, g_ready1); end
        checks++; if (g_err !== 1'b0) begin failures++; $display("FAIL wr_err got=%b exp=0", g_err); end
    endtask

    task automatic test_read();
        // Accepted at ph 1: ALIGN at ph 2,3; beats at cycles 3..6; response at 8.
        run_req(1'b0, 7'h05, 32'h0, 1);
        checks++; if (g_rw_cnt !== 0) begin failures++; $display("FAIL rd_rw_cycles got=%0d exp=0", g_rw_cnt); end
        checks++; if (g_align !== 2) begin failures++; $display("FAIL rd_align got=%0d exp=2", g_align); end
        checks++; if (g_addr1 !== 8'h05) begin failures++; $display("FAIL rd_addr got=%h exp=05", g_addr1); end
        checks++; if (g_resp_cnt !== 1 || g_resp_c !== 8) begin failures++; $display("FAIL rd_resp_timing got=%0d@%0d exp=1@8", g_resp_cnt, g_resp_c); end
        checks++; if (g_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", g_rdata); end
    endtask

    task automatic test_back_to_back();
        int resp1_c = -1, acc_c = -1, resp2_c = -1, npulse = 0, ready_busy = 0;
        logic [31:0] rd2 = 32'h0;
        wait_phase(3);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 7'h09; bus.req_wdata = 32'hA5C30F96;
        @(posedge clk);
        @(negedge clk);
        // Keep a second request (read of the same line) pending while busy.
        bus.req_write = 1'b0; bus.req_wdata = 32'hFFFFFFFF;
        for (int c = 1; c <= 40 && resp2_c < 0; c++) begin
            if (bus.resp_valid) begin
                npulse++;
                if (resp1_c < 0) resp1_c = c;
                else begin resp2_c = c; rd2 = bus.resp_rdata; end
            end
            if ((resp1_c < 0 || resp1_c == c) && bus.req_ready) ready_busy++;
            if (bus.req_ready && bus.req_valid && acc_c < 0) acc_c = c;
            @(negedge clk);
            if (c == acc_c) bus.req_valid = 1'b0;
        end
        bus.req_valid = 1'b0;
        checks++; if (ready_busy !== 0) begin failures++; $display("FAIL b2b_ready_busy got=%0d exp=0", ready_busy); end
        checks++; if (resp1_c !== 1 + WR_LAT) begin failures++; $display("FAIL b2b_resp1 got=%0d exp=%0d", resp1_c, 1 + WR_LAT); end
        checks++; if (acc_c !== resp1_c + 1) begin failures++; $display("FAIL b2b_accept got=%0d exp=%0d", acc_c, resp1_c + 1); end
        checks++; if (npulse !== 2 || resp2_c < 0) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", npulse); end
        checks++; if (rd2 !== 32'hA5C30F96) begin failures++; $display("FAIL b2b_rdata got=%h exp=a5c30f96", rd2); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        int npulse = 0;
        wait_phase(3);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 7'h0C; bus.req_wdata = 32'h11223344;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);   // beat 2
        checks++; if (bus.mem_rw !== 1'b1 || bus.mem_wdata !== 8'h22) begin failures++; $display("FAIL rmb_beat2 got=%b/%h exp=1/22", bus.mem_rw, bus.mem_wdata); end
        rst = 1'b1;
        #1;
        checks++; if (bus.mem_rw !== 1'b0) begin failures++; $display("FAIL rmb_rw_async got=%b exp=0", bus.mem_rw); end
        checks++; if (bus.busy !== 1'b0 || bus.req_ready !== 1'b0) begin failures++; $display("FAIL rmb_busy_ready got=%b/%b exp=0/0", bus.busy, bus.req_ready); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rmb_ready_after got=%b exp=1", bus.req_ready); end
        for (int c = 0; c < 12; c++) begin
            if (bus.resp_valid) npulse++;
            @(negedge clk);
        end
        checks++; if (npulse !== 0) begin failures++; $display("FAIL rmb_no_resp got=%0d exp=0", npulse); end
    endtask

    task automatic test_max_line();
        // Write accepted at ph 0: three ALIGN cycles, first beat at cycle 4.
        run_req(1'b1, 7'h7F, 32'h01234567, 0);
        checks++; if (g_addr1 !== 8'h7F) begin failures++; $display("FAIL max_addr got=%h exp=7f", g_addr1); end
        checks++; if (g_first_rw !== 4 || g_rw_cnt !== 4) begin failures++; $display("FAIL max_beats got=%0d@%0d exp=4@4", g_rw_cnt, g_first_rw); end
        checks++; if (g_wbytes !== 32'h01234567) begin failures++; $display("FAIL max_bytes got=%h exp=01234567", g_wbytes); end
        checks++; if (g_resp_c !== 4 + WR_LAT) begin failures++; $display("FAIL max_wr_resp got=%0d exp=%0d", g_resp_c, 4 + WR_LAT); end
        checks++;
        if ({mem_arr[511], mem_arr[510], mem_arr[509], mem_arr[508]} !== 32'h01234567) begin
            failures++;
            $display("FAIL max_mem_508_511 got=%h exp=01234567",
                     {mem_arr[511], mem_arr[510], mem_arr[509], mem_arr[508]});
        end
        // Read accepted at ph 2: one ALIGN cycle, beats at 2..5, response at 7.
        run_req(1'b0, 7'h7F, 32'h0, 2);
        checks++; if (g_resp_c !== 7 || g_rdata !== 32'h01234567) begin failures++; $display("FAIL max_rd got=%h@%0d exp=01234567@7", g_rdata, g_resp_c); end
    endtask

    task automatic test_readback();
        run_req(1'b1, 7'h03, 32'hCAFEF00D, 1);
        checks++; if (g_err !== 1'b0) begin failures++; $display("FAIL rb_clean_err got=%b exp=0", g_err); end
`ifdef READBACK_CHECK_EN
        checks++; if (g_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL rb_clean_rdata got=%h exp=cafef00d", g_rdata); end
        corrupt_b2 = 1'b1;
        run_req(1'b1, 7'h05, 32'hDEADBEEF, 3);
        corrupt_b2 = 1'b0;
        checks++; if (g_resp_c !== 10) begin failures++; $display("FAIL rb_resp_cycle got=%0d exp=10", g_resp_c); end
        checks++; if (g_err !== 1'b1) begin failures++; $display("FAIL rb_err got=%b exp=1", g_err); end
        checks++; if (g_rdata !== 32'hDE00BEEF) begin failures++; $display("FAIL rb_rdata got=%h exp=de00beef", g_rdata); end
        run_req(1'b1, 7'h05, 32'hDEADBEEF, 3);
        checks++; if (g_err !== 1'b0 || g_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rb_unforced got=%b/%h exp=0/deadbeef", g_err, g_rdata); end
`else
        // Without read-back a write leaves resp_rdata at the last read word.
        checks++; if (g_rdata !== 32'h01234567) begin failures++; $display("FAIL wr_rdata_hold got=%h exp=01234567", g_rdata); end
`endif
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid_burst();
        test_max_line();
        test_readback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
